// File: rtl/cache_port_arbiter_pkg.sv
// Shared type definitions for the data-cache port arbiter.
//   CACHE    : cache command encoding used by every cache client.
//   ArbTypes : arbiter FSM states and the round-robin pick helper.
// No ports (package file).

package CACHE;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } cache_cmd_t;
endpackage

package ArbTypes;
  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Widest requester set supported; narrower sets are zero-padded.
  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  // First eligible index at or after ptr, scanning upward modulo n.
  // Scanned from the farthest offset down so the nearest hit is kept.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] eligible,
    input logic [IDX_W-1:0]   ptr,
    input int unsigned        n
  );
    logic [IDX_W-1:0] win;
    int unsigned      idx;
    win = '0;
    for (int unsigned k = n; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % n;
      if (eligible[idx[IDX_W-1:0]]) win = idx[IDX_W-1:0];
    end
    return win;
  endfunction
endpackage

// File: rtl/cache_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
//   eligible : request vector, one bit per requester
//   ptr      : index with highest priority this round
//   grant    : one-hot winner (all zero when nothing is eligible)
//   idx      : binary index of the winner
//   valid    : at least one requester is eligible

module rr_picker
  import ArbTypes::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [MAX_REQ-1:0] elig_ext;

  always_comb begin
    elig_ext         = '0;
    elig_ext[N-1:0]  = eligible;
    valid            = |eligible;
    idx              = rr_pick(elig_ext, ptr, N);
    grant            = '0;
    for (int unsigned i = 0; i < N; i++) begin
      grant[i] = valid && (32'(idx) == i);
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares one data-cache request port among NREQ
// requesters with registered round-robin grant. The granted command is
// latched so the cache-side request stays stable until ca_respcyc.
//   clk, reset     : clock, asynchronous active-low reset
//   rq_cmd/addr/data : per-requester command, address, store data
//   rq_respcyc     : response strobe to the granted requester only
//   rq_resp_data   : cache response data, broadcast
//   rq_grant       : one-hot owner of the cache port
//   ca_req_*       : registered command/address/data to the cache
//   ca_respcyc, ca_resp_data : cache response
//   proto_err      : sticky, response seen with nothing outstanding

module cache_port_arbiter
  import CACHE::*;
  import ArbTypes::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cache_cmd_t [NREQ-1:0]        rq_cmd,
  input  logic [NREQ-1:0][ADDR_W-1:0]  rq_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]  rq_data,
  output logic [NREQ-1:0]              rq_respcyc,
  output logic [DATA_W-1:0]            rq_resp_data,
  output logic [NREQ-1:0]              rq_grant,
  output cache_cmd_t                   ca_req_cmd,
  output logic [ADDR_W-1:0]            ca_req_addr,
  output logic [DATA_W-1:0]            ca_req_data,
  input  logic                         ca_respcyc,
  input  logic [DATA_W-1:0]            ca_resp_data,
  output logic                         proto_err
);

  arb_state_t          state, state_n;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]    gnt_idx, gnt_idx_n;
  logic [NREQ-1:0]     grant_q, grant_n;
  cache_cmd_t          lat_cmd, lat_cmd_n;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_n;
  logic [DATA_W-1:0]   lat_data, lat_data_n;
  logic                perr, perr_n;

  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = (rq_cmd[i] != IDLE);
    end
  end

  rr_picker #(.N(NREQ)) u_picker (
    .eligible (elig),
    .ptr      (rr_ptr),
    .grant    (pick_grant),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      grant_q  <= '0;
      lat_cmd  <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      perr     <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      gnt_idx  <= gnt_idx_n;
      grant_q  <= grant_n;
      lat_cmd  <= lat_cmd_n;
      lat_addr <= lat_addr_n;
      lat_data <= lat_data_n;
      perr     <= perr_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    gnt_idx_n  = gnt_idx;
    grant_n    = grant_q;
    lat_cmd_n  = lat_cmd;
    lat_addr_n = lat_addr;
    lat_data_n = lat_data;
    perr_n     = perr;
    rq_respcyc = '0;

    case (state)
      ARB: begin
        // A response with nothing outstanding is a protocol violation.
        if (ca_respcyc) perr_n = 1'b1;
        if (pick_valid) begin
          state_n   = BUSY;
          grant_n   = pick_grant;
          gnt_idx_n = pick_idx;
          // One-hot mux avoids indexing the requester arrays with a
          // pointer wider than the array index.
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
              lat_cmd_n  = rq_cmd[i];
              lat_addr_n = rq_addr[i];
              lat_data_n = rq_data[i];
            end
          end
        end
      end
      BUSY: begin
        if (ca_respcyc) begin
          rq_respcyc = grant_q;
          state_n    = ARB;
          grant_n    = '0;
          lat_cmd_n  = IDLE;
          rr_ptr_n   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 2'd1;
        end
      end
      default: state_n = ARB;
    endcase
  end

  assign rq_resp_data = ca_resp_data;
  assign rq_grant     = grant_q;
  assign ca_req_cmd   = lat_cmd;
  assign ca_req_addr  = lat_addr;
  assign ca_req_data  = lat_data;
  assign proto_err    = perr;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with NREQ=2: a table of per-cycle
// vectors plus hand-written sequences for asynchronous reset behaviour.

module tb_cache_port_arbiter;
  import CACHE::*;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset;
  cache_cmd_t [NREQ-1:0]        rq_cmd;
  logic [NREQ-1:0][ADDR_W-1:0]  rq_addr;
  logic [NREQ-1:0][DATA_W-1:0]  rq_data;
  logic [NREQ-1:0]              rq_respcyc;
  logic [DATA_W-1:0]            rq_resp_data;
  logic [NREQ-1:0]              rq_grant;
  cache_cmd_t                   ca_req_cmd;
  logic [ADDR_W-1:0]            ca_req_addr;
  logic [DATA_W-1:0]            ca_req_data;
  logic                         ca_respcyc;
  logic [DATA_W-1:0]            ca_resp_data;
  logic                         proto_err;

  cache_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rq_cmd       (rq_cmd),
    .rq_addr      (rq_addr),
    .rq_data      (rq_data),
    .rq_respcyc   (rq_respcyc),
    .rq_resp_data (rq_resp_data),
    .rq_grant     (rq_grant),
    .ca_req_cmd   (ca_req_cmd),
    .ca_req_addr  (ca_req_addr),
    .ca_req_data  (ca_req_data),
    .ca_respcyc   (ca_respcyc),
    .ca_resp_data (ca_resp_data),
    .proto_err    (proto_err)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    cache_cmd_t  c0;
    logic [63:0] a0, d0;
    cache_cmd_t  c1;
    logic [63:0] a1, d1;
    logic        crc;
    logic [63:0] crd;
    logic [1:0]  e_gnt;
    cache_cmd_t  e_cmd;
    logic        e_chk;   // compare ca_req_addr/data on this row
    logic [63:0] e_addr, e_data;
    logic [1:0]  e_resp;
    logic        e_perr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    cache_cmd_t c0, logic [63:0] a0, logic [63:0] d0,
    cache_cmd_t c1, logic [63:0] a1, logic [63:0] d1,
    logic crc, logic [63:0] crd,
    logic [1:0] eg, cache_cmd_t ec, logic ek,
    logic [63:0] ea, logic [63:0] ed, logic [1:0] er, logic ep);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.d0 = d0;
    v.c1 = c1; v.a1 = a1; v.d1 = d1;
    v.crc = crc; v.crd = crd;
    v.e_gnt = eg; v.e_cmd = ec; v.e_chk = ek;
    v.e_addr = ea; v.e_data = ed; v.e_resp = er; v.e_perr = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rq_cmd[0]  = vt[i].c0; rq_addr[0] = vt[i].a0; rq_data[0] = vt[i].d0;
      rq_cmd[1]  = vt[i].c1; rq_addr[1] = vt[i].a1; rq_data[1] = vt[i].d1;
      ca_respcyc = vt[i].crc; ca_resp_data = vt[i].crd;
      #2;
      chk($sformatf("row%0d.grant", i), 64'(rq_grant), 64'(vt[i].e_gnt));
      chk($sformatf("row%0d.ca_cmd", i), 64'(ca_req_cmd), 64'(vt[i].e_cmd));
      if (vt[i].e_chk) begin
        chk($sformatf("row%0d.ca_addr", i), ca_req_addr, vt[i].e_addr);
        chk($sformatf("row%0d.ca_data", i), ca_req_data, vt[i].e_data);
      end
      chk($sformatf("row%0d.respcyc", i), 64'(rq_respcyc), 64'(vt[i].e_resp));
      chk($sformatf("row%0d.resp_data", i), rq_resp_data, vt[i].crd);
      chk($sformatf("row%0d.proto_err", i), 64'(proto_err), 64'(vt[i].e_perr));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Part 1: single READ, then FLUSH answered in its first BUSY cycle.
    vt.push_back(mk(READ, 64'h1000, 64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b00, IDLE,  1'b1, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1000, 64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b01, READ,  1'b1, 64'h1000, 64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1000, 64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b01, READ,  1'b1, 64'h1000, 64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1000, 64'h0,  IDLE,  64'h0,    64'h0,  1'b1, 64'hDEADBEEF,
                    2'b01, READ,  1'b1, 64'h1000, 64'h0,  2'b01, 1'b0));
    vt.push_back(mk(IDLE, 64'h0,    64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h4000, 64'hA4, FLUSH, 64'h5000, 64'h51, 1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h4000, 64'hA4, FLUSH, 64'h5000, 64'h51, 1'b1, 64'h1234,
                    2'b10, FLUSH, 1'b1, 64'h5000, 64'h51, 2'b10, 1'b0));
    vt.push_back(mk(READ, 64'h4000, 64'hA4, IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h4000, 64'hA4, IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b01, READ,  1'b1, 64'h4000, 64'hA4, 2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h4000, 64'hA4, IDLE,  64'h0,    64'h0,  1'b1, 64'hCAFE,
                    2'b01, READ,  1'b1, 64'h4000, 64'hA4, 2'b01, 1'b0));
    vt.push_back(mk(IDLE, 64'h0,    64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    // Part 2 (rows 11..27): contention from rr_ptr=0, mid-BUSY address
    // change, then a stray response while idle.
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h2000, 64'h55, 1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h2000, 64'h55, 1'b0, 64'h0,
                    2'b01, READ,  1'b1, 64'h1100, 64'h10, 2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h2000, 64'h55, 1'b1, 64'h11,
                    2'b01, READ,  1'b1, 64'h1100, 64'h10, 2'b01, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h2000, 64'h55, 1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h2000, 64'h55, 1'b0, 64'h0,
                    2'b10, WRITE, 1'b1, 64'h2000, 64'h55, 2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b0, 64'h0,
                    2'b10, WRITE, 1'b1, 64'h2000, 64'h55, 2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b1, 64'h22,
                    2'b10, WRITE, 1'b1, 64'h2000, 64'h55, 2'b10, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b0, 64'h0,
                    2'b01, READ,  1'b1, 64'h1100, 64'h10, 2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b1, 64'h33,
                    2'b01, READ,  1'b1, 64'h1100, 64'h10, 2'b01, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b0, 64'h0,
                    2'b10, WRITE, 1'b1, 64'h3000, 64'h66, 2'b00, 1'b0));
    vt.push_back(mk(READ, 64'h1100, 64'h10, WRITE, 64'h3000, 64'h66, 1'b1, 64'h44,
                    2'b10, WRITE, 1'b1, 64'h3000, 64'h66, 2'b10, 1'b0));
    vt.push_back(mk(IDLE, 64'h0,    64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(IDLE, 64'h0,    64'h0,  IDLE,  64'h0,    64'h0,  1'b1, 64'h99,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b0));
    vt.push_back(mk(IDLE, 64'h0,    64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b1));
    vt.push_back(mk(IDLE, 64'h0,    64'h0,  IDLE,  64'h0,    64'h0,  1'b0, 64'h0,
                    2'b00, IDLE,  1'b0, 64'h0,    64'h0,  2'b00, 1'b1));

    // Reset state
    reset        = 1'b0;
    rq_cmd       = '{IDLE, IDLE};
    rq_addr      = '0;
    rq_data      = '0;
    ca_respcyc   = 1'b0;
    ca_resp_data = '0;
    #12;
    chk("rst.grant", 64'(rq_grant), 64'h0);
    chk("rst.ca_cmd", 64'(ca_req_cmd), 64'(IDLE));
    chk("rst.ca_addr", ca_req_addr, 64'h0);
    chk("rst.respcyc", 64'(rq_respcyc), 64'h0);
    chk("rst.proto_err", 64'(proto_err), 64'h0);
    #6 reset = 1'b1;
    @(posedge clk); #1;

    apply(0, 11);

    // Asynchronous reset in BUSY, late response, re-arbitration from 0.
    rq_cmd[0] = READ;  rq_addr[0] = 64'h8000; rq_data[0] = 64'h80;
    rq_cmd[1] = WRITE; rq_addr[1] = 64'h7000; rq_data[1] = 64'h77;
    @(posedge clk); #1;
    chk("ar.busy_grant", 64'(rq_grant), 64'h2);
    chk("ar.busy_cmd", 64'(ca_req_cmd), 64'(WRITE));
    chk("ar.busy_addr", ca_req_addr, 64'h7000);
    #3 reset = 1'b0;
    #1;
    chk("ar.async_cmd", 64'(ca_req_cmd), 64'(IDLE));
    chk("ar.async_grant", 64'(rq_grant), 64'h0);
    chk("ar.async_addr", ca_req_addr, 64'h0);
    #1 reset = 1'b1;
    ca_respcyc = 1'b1; ca_resp_data = 64'hBAD;
    #1;
    chk("ar.late_respcyc", 64'(rq_respcyc), 64'h0);
    @(posedge clk); #1;
    ca_respcyc = 1'b0;
    chk("ar.late_perr", 64'(proto_err), 64'h1);
    chk("ar.rearb_grant", 64'(rq_grant), 64'h1);
    chk("ar.rearb_cmd", 64'(ca_req_cmd), 64'(READ));
    chk("ar.rearb_addr", ca_req_addr, 64'h8000);
    ca_respcyc = 1'b1; ca_resp_data = 64'h5A;
    #1;
    chk("ar.resp", 64'(rq_respcyc), 64'h1);
    chk("ar.resp_data", rq_resp_data, 64'h5A);
    @(posedge clk); #1;
    ca_respcyc = 1'b0;
    rq_cmd = '{IDLE, IDLE};
    #1;
    chk("ar.idle_grant", 64'(rq_grant), 64'h0);
    reset = 1'b0;
    #1;
    chk("ar.perr_clear", 64'(proto_err), 64'h0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    apply(11, vt.size());

    reset = 1'b0;
    #1;
    chk("end.perr_clear", 64'(proto_err), 64'h0);
    chk("end.grant", 64'(rq_grant), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares the single data-cache request port among NREQ requesters: the memory pipeline, the page walker and the prefetcher. Each requester sees a private copy of the cache command/response protocol. The cache itself sees exactly one outstanding command at a time. Grant is round-robin and registered, and the granted command is latched so the cache-side request is stable until ca_respcyc.

Parameters:
NREQ, 2, number of requesters (2..4); requester 0 is the memory pipeline.
ADDR_W, 64, request address width.
DATA_W, 64, request/response data width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
rq_cmd  in  NREQ x CACHE::cache_cmd_t  per-requester command; IDLE = no request.
rq_addr  in  NREQ x ADDR_W  per-requester address.
rq_data  in  NREQ x DATA_W  per-requester store data.
rq_respcyc  out  NREQ  one-cycle response strobe to the granted requester.
rq_resp_data  out  DATA_W  cache response data, broadcast to all requesters.
rq_grant  out  NREQ  one-hot; the requester currently owning the cache port.
ca_req_cmd  out  CACHE::cache_cmd_t  command to the cache.
ca_req_addr  out  ADDR_W  address to the cache.
ca_req_data  out  DATA_W  data to the cache.
ca_respcyc  in  1  cache response strobe.
ca_resp_data  in  DATA_W  cache response data.
proto_err  out  1  sticky flag: ca_respcyc seen while no command was outstanding.

Behaviour:
- Reset (reset==0, asynchronous): state=ARB, rr_ptr=0, rq_grant=0, ca_req_cmd=IDLE, ca_req_addr=0, ca_req_data=0, rq_respcyc=0, proto_err=0. Latched command registers are cleared.
- State ARB:
  - Requester i is eligible when rq_cmd[i]!=IDLE.
  - Winner is the first eligible index at or after rr_ptr, scanning upward modulo NREQ.
  - On the edge, latch the winner's cmd/addr/data into lat_*, set rq_grant one-hot, go to BUSY.
  - With no eligible requester, stay in ARB.
- State BUSY:
  - ca_req_cmd/addr/data = lat_*; they are driven from registers only, with no combinational path from rq_* to ca_req_*.
  - When ca_respcyc==1, in the same cycle: rq_respcyc[granted]=1 and rq_resp_data=ca_resp_data.
  - On that edge: rr_ptr = granted+1 mod NREQ, rq_grant=0, lat_cmd=IDLE, go to ARB.
  - With no ca_respcyc, hold all values with no timeout.
- In ARB, ca_req_cmd=IDLE.
- rq_respcyc is 0 for every non-granted requester, and for all requesters outside the response cycle.
- Latency:
  - Requester asserts at cycle t; the cache sees the command at t+1 at the earliest.
  - Minimum occupancy is 2 cycles per transaction: a same-cycle ca_respcyc at t+1 returns the port to ARB at t+2.
  - Back-to-back transactions incur one ARB cycle.
- rq_resp_data is combinationally equal to ca_resp_data at all times; it is only meaningful when rq_respcyc is set.
- Requester contract:
  - A requester keeps rq_cmd stable until it sees its rq_respcyc.
  - It may present a new command in the cycle after rq_respcyc.
  - Changes to rq_* of the granted requester during BUSY are ignored, because the latched values are used.
- ca_respcyc in ARB: ignored for routing (no rq_respcyc); proto_err<=1, held until reset.
- Simultaneous requests: round-robin only. A requester that was just served has the lowest priority on the next arbitration. No requester waits more than NREQ-1 grants.
- Reset mid-transaction: the port returns to ARB immediately. A late ca_respcyc for the aborted command sets proto_err. The cache must be reset together with the arbiter.
- NREQ==1: the grant is always to index 0; the same timing applies.

Decomposition:
- Package CACHE (existing): cache_cmd_t (IDLE/READ/WRITE/FLUSH), reused unchanged.
- New package ArbTypes: arb_state_t {ARB, BUSY}, and the function rr_pick(eligible, ptr) returning the winning index.
- Sub-module rr_picker: combinational round-robin priority encoder, one-hot out, with a valid flag. It is reusable by other shared ports.

Test Plan:
1. Reset release, then rq_cmd[0]=READ addr=0x1000 at t0 -> t1 ca_req_cmd=READ, ca_req_addr=0x1000, rq_grant=01; ca_respcyc at t3 with data 0xDEADBEEF -> rq_respcyc[0]=1 at t3 with rq_resp_data=0xDEADBEEF; rq_grant=00 at t4.
2. rq_cmd[0]=READ and rq_cmd[1]=WRITE (addr 0x2000, data 0x55) both at t0, rr_ptr=0 -> requester 0 served first; then requester 1 sees ca_req_cmd=WRITE, addr=0x2000, data=0x55. Repeated continuous requests alternate grants 0,1,0,1.
3. Requester 1 changes rq_addr to 0x3000 mid-BUSY -> ca_req_addr stays 0x2000 until ca_respcyc.
4. ca_respcyc pulsed while in ARB with no requests -> no rq_respcyc; proto_err=1 and remains 1 until reset.
5. reset driven low in BUSY, asynchronously, mid-cycle -> ca_req_cmd=IDLE and rq_grant=0 without waiting for a clock edge; after release, a pending request is re-arbitrated from rr_ptr=0.
6. FLUSH from requester 1 with ca_respcyc in the same cycle the command appears -> rq_respcyc[1] asserts that cycle; requester 0's waiting READ appears on ca_req_cmd two cycles later.
